// File: rtl/db_multi.sv
// Multi-channel switch debouncer: 2-flop synchroniser, tick-strobed stability counter, rise/fall pulses.
// Optional per-channel long-press pulse, enabled by defining DB_MULTI_LONG_PRESS_EN.
module db_multi #(
  parameter int CH     = 4,
  parameter int N      = 20,
  parameter int STABLE = 4,
  parameter int LONG   = 100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          tick,
  output logic [CH-1:0] long_press
);

  localparam int CW = $clog2(STABLE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  if (CH < 1 || CH > 32 || N < 1 || STABLE < 2 || STABLE > 15 || LONG < 1) begin : g_bad_param
    $error("db_multi: parameter out of range");
  end

  logic [N-1:0]  q;
  logic [CH-1:0] s_meta;
  logic [CH-1:0] s;
  logic [CW-1:0] cnt [CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= q + 1'b1;
  end

  // The strobe is the all-ones divider state, so it is low throughout reset.
  assign tick = &q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_meta <= '0;
      s      <= '0;
    end else begin
      s_meta <= sw;
      s      <= s_meta;
    end
  end

  // A single agreeing sample clears the count, so only an unbroken run of STABLE disagreeing ticks flips db.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db   <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      if (tick) begin
        for (int i = 0; i < CH; i++) begin
          if (s[i] == db[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            db[i]   <= ~db[i];
            cnt[i]  <= '0;
            rise[i] <= ~db[i];
            fall[i] <= db[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef DB_MULTI_LONG_PRESS_EN
  localparam int HW = $clog2(LONG + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG - 1);

  logic [HW-1:0] hold [CH];

  // Saturating at LONG makes the pulse fire once per press; only db returning low re-arms it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_press <= '0;
      for (int i = 0; i < CH; i++) hold[i] <= '0;
    end else begin
      long_press <= '0;
      for (int i = 0; i < CH; i++) begin
        if (!db[i]) begin
          hold[i] <= '0;
        end else if (tick && hold[i] != HOLD_MAX) begin
          hold[i] <= hold[i] + 1'b1;
          if (hold[i] == HOLD_LAST) long_press[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_db_multi.sv
// Directed self-checking bench for db_multi with N=4 (tick every 16 clk), STABLE=4, CH=4, LONG=10.
module tb_db_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw = 4'b0000;
  logic [3:0] db, rise, fall, long_press;
  logic       tick;

  int checks = 0;
  int fails = 0;
  int rise1_cnt = 0;
  int lp2_cnt = 0;

`ifdef DB_MULTI_LONG_PRESS_EN
  localparam int LP_EN = 1;
`else
  localparam int LP_EN = 0;
`endif

  db_multi #(.CH(4), .N(4), .STABLE(4), .LONG(10)) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db), .rise(rise),
    .fall(fall), .tick(tick), .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge; the stimulus reads them #1 later.
  always @(negedge clk) begin
    if (rise[1] === 1'b1) rise1_cnt++;
    if (long_press[2] === 1'b1) lp2_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    sw = v;
  endtask

  // Leaves the bench on the falling edge just after the next tick has been consumed.
  task automatic nextTick();
    int n = 0;
    while (tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tick_seen", 32'(tick), 32'd1);
    @(negedge clk);
  endtask

  task automatic ticks(input int k);
    repeat (k) nextTick();
  endtask

  initial begin
    int n;
    int bad;
    int r0;

    repeat (3) @(negedge clk);
    checkOutput("reset_db", 32'(db), 32'h0);
    checkOutput("reset_rise_fall", 32'(rise | fall), 32'h0);
    checkOutput("reset_tick", 32'(tick), 32'h0);
    checkOutput("reset_long_press", 32'(long_press), 32'h0);

    reset = 1'b0;
    n = 0;
    while (tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first_tick_cycle", 32'(n), 32'd15);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 40);
    checkOutput("tick_period", 32'(n), 32'd16);

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if ((db | rise | fall) !== 4'b0000) bad++;
    end
    checkOutput("idle_quiet", 32'(bad), 32'd0);
    nextTick();

    applyStimulus(4'b0001);
    ticks(3);
    checkOutput("press_pending", 32'(db), 32'h0);
    nextTick();
    checkOutput("press_db", 32'(db), 32'h1);
    checkOutput("press_rise", 32'(rise), 32'h1);
    checkOutput("press_fall", 32'(fall), 32'h0);
    @(negedge clk);
    checkOutput("press_rise_one_clk", 32'(rise), 32'h0);
    checkOutput("press_db_hold", 32'(db), 32'h1);

    #1 r0 = rise1_cnt;
    applyStimulus(4'b0011);
    ticks(3);
    checkOutput("bounce_after_3", 32'(db), 32'h1);
    applyStimulus(4'b0001);
    nextTick();
    checkOutput("bounce_abort", 32'(db), 32'h1);
    applyStimulus(4'b0011);
    ticks(3);
    checkOutput("bounce_no_early", 32'(db), 32'h1);
    nextTick();
    checkOutput("bounce_db", 32'(db), 32'h3);
    checkOutput("bounce_rise", 32'(rise), 32'h2);
    @(negedge clk);
    #1 checkOutput("bounce_one_rise", 32'(rise1_cnt - r0), 32'd1);

    applyStimulus(4'b0010);
    ticks(3);
    checkOutput("release_pending", 32'(db), 32'h3);
    nextTick();
    checkOutput("release_db", 32'(db), 32'h2);
    checkOutput("release_fall", 32'(fall), 32'h1);
    checkOutput("release_rise", 32'(rise), 32'h0);
    @(negedge clk);
    checkOutput("release_fall_one_clk", 32'(fall), 32'h0);

    applyStimulus(4'b0110);
    repeat (5) @(negedge clk);
    applyStimulus(4'b0010);
    ticks(4);
    checkOutput("glitch_ignored", 32'(db), 32'h2);

    applyStimulus(4'b0000);
    ticks(4);
    checkOutput("release1_db", 32'(db), 32'h0);
    checkOutput("release1_fall", 32'(fall), 32'h2);

    applyStimulus(4'b1111);
    ticks(4);
    checkOutput("all_db", 32'(db), 32'hF);
    checkOutput("all_rise", 32'(rise), 32'hF);
    @(negedge clk);
    checkOutput("all_rise_one_clk", 32'(rise), 32'h0);
    applyStimulus(4'b0000);
    ticks(4);
    checkOutput("all_release_db", 32'(db), 32'h0);
    checkOutput("all_fall", 32'(fall), 32'hF);

    applyStimulus(4'b1111);
    ticks(2);
    reset = 1'b1;
    #1;
    checkOutput("midreset_db", 32'(db), 32'h0);
    checkOutput("midreset_pulses", 32'(rise | fall), 32'h0);
    checkOutput("midreset_tick", 32'(tick), 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("in_reset_quiet", 32'(db | rise | fall), 32'h0);
    reset = 1'b0;
    ticks(3);
    checkOutput("held_sw_pending", 32'(db), 32'h0);
    nextTick();
    checkOutput("held_sw_db", 32'(db), 32'hF);
    checkOutput("held_sw_rise", 32'(rise), 32'hF);

    applyStimulus(4'b0000);
    ticks(4);
    checkOutput("held_release_db", 32'(db), 32'h0);

    #1 checkOutput("lp2_none_yet", 32'(lp2_cnt), 32'd0);
    applyStimulus(4'b0100);
    ticks(4);
    checkOutput("lp_db_rise", 32'(db), 32'h4);
    ticks(9);
    #1 checkOutput("lp_not_early", 32'(lp2_cnt), 32'd0);
    nextTick();
    checkOutput("lp_pulse", 32'(long_press), (LP_EN != 0) ? 32'h4 : 32'h0);
    @(negedge clk);
    checkOutput("lp_one_clk", 32'(long_press), 32'h0);
    ticks(12);
    #1 checkOutput("lp_once", 32'(lp2_cnt), 32'(LP_EN));
    applyStimulus(4'b0000);
    ticks(4);
    checkOutput("lp_release_db", 32'(db), 32'h0);
    applyStimulus(4'b0100);
    ticks(14);
    #1 checkOutput("lp_rearm", 32'(lp2_cnt), 32'(2 * LP_EN));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/db_multi.md
Name: db_multi

Overview:
- Multi-channel switch debouncer; successor to the single-switch debounce FSM.
- Runs fully on one clock: the sample tick is a clock-enable, not a derived clock.
- Channel count, tick period and stability threshold are parameters.
- Adds an input synchroniser per channel and one-cycle rise/fall event pulses.
- Sits between raw board switches/buttons and user logic.

Parameters:
- CH, 4: number of independent switch channels (1..32).
- N, 20: tick divider bits; tick period is 2^N clk cycles (2^20 × 20 ns ≈ 21 ms).
- STABLE, 4: consecutive disagreeing ticks required to flip the debounced level (2..15).
- LONG, 100: ticks of continuous debounced-high before the long-press pulse (LONG_PRESS_EN only).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- sw, input, CH: raw asynchronous switch inputs.
- db, output, CH: debounced levels.
- rise, output, CH: one-clk pulse when db[i] goes 0→1.
- fall, output, CH: one-clk pulse when db[i] goes 1→0.
- tick, output, 1: one-clk sample strobe.
- long_press, output, CH: one-clk pulse on long hold (LONG_PRESS_EN only; otherwise tied 0).

Behaviour:
- Reset (asynchronous): the following are all 0:
  - divider q, tick
  - synchroniser flops
  - per-channel counters
  - db, rise, fall, long_press
- Divider:
  - q increments every clk and wraps mod 2^N.
  - tick = 1 for exactly the cycle where q == 2^N-1.
  - First tick occurs 2^N-1 cycles after reset release.
- Synchroniser: sw[i] passes through 2 flops → s[i]; 2-cycle latency, no metastability filtering beyond that.
- Per-channel state: debounced level db[i] plus disagreement counter cnt[i] (width ceil(log2(STABLE))+1). These replace the 8-state one-hot path; the behaviour is equivalent.
- Clock cycles with tick=0: db and cnt hold.
- Clock cycles with tick=1:
  - If s[i] == db[i]: cnt[i] ← 0. A single agreeing sample aborts a pending change.
  - Else if cnt[i] == STABLE-1: db[i] ← ~db[i], cnt[i] ← 0, and rise[i] or fall[i] = 1 on the next cycle (same edge db updates).
  - Else: cnt[i] ← cnt[i]+1.
- Consequence: a change is accepted on the STABLE-th consecutive tick at which the synchronised input differs from db. The behaviour is symmetric for press and release.
- rise/fall:
  - Registered, high exactly one clk, coincident with the first cycle of the new db value.
  - Never both high for the same channel.
- Channels are fully independent; simultaneous changes on several channels produce simultaneous pulses.
- Reset mid-count: counters clear, db returns to 0, no pulse is emitted.
- sw held high through reset release: db rises after STABLE ticks, with a rise pulse.

Optional Feature:
- Macro: DB_MULTI_LONG_PRESS_EN.
- Enabled:
  - Each channel has a hold counter (width ceil(log2(LONG+1))). It clears when db[i]=0 and increments on tick while db[i]=1, saturating at LONG.
  - long_press[i] pulses one clk on the tick at which the counter reaches LONG.
  - Fires once per press; re-arms only after db[i] returns to 0.
  - Reset clears the hold counter.
- Disabled: no hold counters are instantiated; long_press is constant 0; LONG is ignored.

Test Plan (sim with N=4, so tick every 16 clk; STABLE=4; CH=4):
- Reset release, sw=0 → db=0, no rise/fall for 1000 clk; first tick at cycle 15, then every 16.
- Clean press sw[0]=1 held → db[0]=1 on the 4th tick after sync; rise[0] one clk coincident; other channels unaffected.
- Bounce sw[1]: high for 3 ticks, low for 1 tick, high again → no change until 4 further consecutive high ticks; exactly one rise[1].
- Release after press, sw[0]=0 held → db[0]=0 on the 4th tick; fall[0] one clk. A glitch shorter than 16 clk that straddles no tick → no effect.
- All four channels toggled simultaneously → db=4'hF on the same cycle, rise=4'hF for one clk. Assert reset during a pending count → all outputs 0 at once, no pulse.
- With DB_MULTI_LONG_PRESS_EN, LONG=10:
  - Hold sw[2] → long_press[2] pulses once, 10 ticks after db[2] rose.
  - Keep holding → no further pulse.
  - Release and press again → pulses again.
  - Without the macro → long_press stays 0.
